// File: rtl/color_sensor_emu.sv
// color_sensor_emu
//   Emulates a colour-to-frequency light sensor. For the selected filter,
//   the sensor emits a square wave whose half-period (in clkus cycles)
//   comes from a small writable table, or from DARK_HALF when the LED is
//   off. Any change of filter or LED restarts a settle window, during which
//   the wave is held low. A channel whose half-period is 0 stays silent.
//
// Ports
//   clkus     in   1 MHz system clock, the only clock
//   rst       in   synchronous active-high reset
//   select    in   filter select {S2,S3}: 00=R, 11=G, 01=B, 10=clear
//   led_en    in   illumination LED on; low selects the dark half-period
//   cfg_we    in   one-cycle write strobe for a half-period register
//   cfg_sel   in   register index to write (same encoding as select)
//   cfg_half  in   half-period in cycles; 0 silences the channel
//   wave      out  emulated sensor square wave
//   settled   out  high while the wave generator is running
//   edge_cnt  out  rising edges of wave since the last select/led_en change
module color_sensor_emu #(
   parameter int SETTLE    = 100,
   parameter int DARK_HALF = 250
) (
   input  logic        clkus,
   input  logic        rst,
   input  logic [1:0]  select,
   input  logic        led_en,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_sel,
   input  logic [7:0]  cfg_half,
   output logic        wave,
   output logic        settled,
   output logic [15:0] edge_cnt
);

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_RUN    = 2'd1,
      ST_SILENT = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [7:0]       half_r [4];
   logic [1:0]       sel_q;
   logic             led_q;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] half_lat, half_nxt;
   logic [CNT_W-1:0] eff_half;
   logic             wave_nxt;
   logic [15:0]      edge_nxt;
   logic             change;
   logic             settle_done;
   logic             phase_done;

   // A change is seen one cycle after the input moves; sel_q/led_q then
   // track the new value, so eff_half already reflects the new channel.
   assign change      = (select != sel_q) || (led_en != led_q);
   assign eff_half    = led_q ? CNT_W'(half_r[sel_q]) : CNT_W'(DARK_HALF);
   assign settle_done = (cnt == CNT_W'(SETTLE - 1));
   // half_lat is never 0 while running, so the subtraction cannot wrap.
   assign phase_done  = (cnt == half_lat - CNT_W'(1));

   // Half-period table, indexed by select code. Reset wins over a write.
   always_ff @(posedge clkus) begin
      if (rst) begin
         half_r[0] <= 8'd50;   // R
         half_r[1] <= 8'd75;   // B
         half_r[2] <= 8'd25;   // clear
         half_r[3] <= 8'd100;  // G
      end else if (cfg_we) begin
         half_r[cfg_sel] <= cfg_half;
      end
   end

   // State and datapath registers
   always_ff @(posedge clkus) begin
      if (rst) begin
         state    <= ST_SETTLE;
         cnt      <= '0;
         half_lat <= '0;
         wave     <= 1'b0;
         settled  <= 1'b0;
         edge_cnt <= 16'd0;
         sel_q    <= select;
         led_q    <= led_en;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         half_lat <= half_nxt;
         wave     <= wave_nxt;
         settled  <= (state_nxt == ST_RUN);
         edge_cnt <= edge_nxt;
         sel_q    <= select;
         led_q    <= led_en;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (change) begin
         state_nxt = ST_SETTLE;
      end else begin
         case (state)
            ST_SETTLE: if (settle_done) state_nxt = (eff_half != '0) ? ST_RUN : ST_SILENT;
            ST_RUN:    if (phase_done)  state_nxt = (eff_half != '0) ? ST_RUN : ST_SILENT;
            ST_SILENT: if (eff_half != '0) state_nxt = ST_RUN;
            default:   state_nxt = ST_SETTLE;
         endcase
      end
   end

   // Datapath next values
   always_comb begin
      cnt_nxt  = cnt;
      half_nxt = half_lat;
      wave_nxt = wave;
      edge_nxt = edge_cnt;
      if (change) begin
         cnt_nxt  = '0;
         wave_nxt = 1'b0;
         edge_nxt = 16'd0;
      end else begin
         case (state)
            ST_SETTLE: begin
               wave_nxt = 1'b0;
               if (settle_done) begin
                  cnt_nxt  = '0;
                  half_nxt = eff_half;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (phase_done) begin
                  // Toggle point is the only place a new half-period is
                  // picked up, so a register write never cuts a half short.
                  cnt_nxt  = '0;
                  half_nxt = eff_half;
                  if (eff_half == '0) begin
                     wave_nxt = 1'b0;
                  end else begin
                     wave_nxt = ~wave;
                     if (!wave) edge_nxt = edge_cnt + 16'd1;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ST_SILENT: begin
               cnt_nxt  = '0;
               wave_nxt = 1'b0;
               half_nxt = eff_half;
            end
            default: begin
               cnt_nxt  = '0;
               wave_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_color_sensor_emu.sv
// Directed bench for color_sensor_emu with default parameters
// (SETTLE=100, DARK_HALF=250). Inputs change and outputs are sampled on the
// falling edge. Offsets in comments count rising edges after the reset or
// change-event edge (offset 0).
module tb_color_sensor_emu;

   logic        clkus;
   logic        rst;
   logic [1:0]  select;
   logic        led_en;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic [7:0]  cfg_half;
   logic        wave;
   logic        settled;
   logic [15:0] edge_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   color_sensor_emu #(.SETTLE(100), .DARK_HALF(250)) dut (
      .clkus    (clkus),
      .rst      (rst),
      .select   (select),
      .led_en   (led_en),
      .cfg_we   (cfg_we),
      .cfg_sel  (cfg_sel),
      .cfg_half (cfg_half),
      .wave     (wave),
      .settled  (settled),
      .edge_cnt (edge_cnt)
   );

   initial clkus = 1'b0;
   always #5 clkus = ~clkus;

   task automatic step(input int n);
      repeat (n) @(negedge clkus);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   initial begin
      rst      = 1'b1;
      select   = 2'b00;
      led_en   = 1'b1;
      cfg_we   = 1'b0;
      cfg_sel  = 2'b00;
      cfg_half = 8'd0;

      // Reset, red channel (half 50)
      step(2);
      chk("rst_wave", wave, 0);
      chk("rst_settled", settled, 0);
      chk("rst_edge", edge_cnt, 0);
      rst = 1'b0;
      step(99);                                   // 99
      chk("settle_last_settled", settled, 0);
      chk("settle_last_wave", wave, 0);
      step(1);                                    // 100
      chk("run_settled", settled, 1);
      step(49);                                   // 149
      chk("r_low_149", wave, 0);
      step(1);                                    // 150
      chk("r_rise_150", wave, 1);
      chk("r_edge_150", edge_cnt, 1);
      step(50);                                   // 200
      chk("r_fall_200", wave, 0);
      step(1900);                                 // 2100
      chk("r_edge_2100", edge_cnt, 20);

      // R -> G -> B at 2000-cycle intervals, counts read 1960 in
      select = 2'b10;
      step(11);
      select = 2'b00;
      step(1);                                    // R 0
      chk("win_r_clear", edge_cnt, 0);
      step(1960);
      chk("win_r_edges", edge_cnt, 19);
      step(39);
      select = 2'b11;
      step(1);                                    // G 0
      chk("win_g_clear", edge_cnt, 0);
      step(1960);
      chk("win_g_edges", edge_cnt, 9);
      step(39);
      select = 2'b01;
      step(1);                                    // B 0
      chk("win_b_clear", edge_cnt, 0);
      step(1960);
      chk("win_b_edges", edge_cnt, 12);
      step(39);

      // Dark output (half 250), then LED on mid-period
      select = 2'b00;
      led_en = 1'b0;
      step(1);                                    // 0
      chk("dark_clear", edge_cnt, 0);
      step(349);                                  // 349
      chk("dark_low_349", wave, 0);
      step(1);                                    // 350
      chk("dark_rise_350", wave, 1);
      step(249);                                  // 599
      chk("dark_high_599", wave, 1);
      step(1);                                    // 600
      chk("dark_fall_600", wave, 0);
      chk("dark_edge_600", edge_cnt, 1);
      step(100);                                  // 700
      led_en = 1'b1;
      step(1);                                    // 0
      chk("led_on_edge", edge_cnt, 0);
      chk("led_on_wave", wave, 0);
      chk("led_on_settled", settled, 0);
      step(100);                                  // 100
      chk("led_on_run", settled, 1);
      step(50);                                   // 150
      chk("led_on_rise_150", wave, 1);

      // Mid-half-period write of 20 to the running red channel
      step(20);                                   // 170
      cfg_we   = 1'b1;
      cfg_sel  = 2'b00;
      cfg_half = 8'd20;
      step(1);                                    // 171
      cfg_we   = 1'b0;
      step(28);                                   // 199
      chk("wr_old_half_199", wave, 1);
      step(1);                                    // 200
      chk("wr_old_half_200", wave, 0);
      step(19);                                   // 219
      chk("wr_new_half_219", wave, 0);
      step(1);                                    // 220
      chk("wr_new_half_220", wave, 1);

      // Silence the channel while high, then resume at 10
      step(5);                                    // 225
      cfg_we   = 1'b1;
      cfg_half = 8'd0;
      step(1);                                    // 226
      cfg_we   = 1'b0;
      step(13);                                   // 239
      chk("sil_high_239", wave, 1);
      chk("sil_run_239", settled, 1);
      step(1);                                    // 240
      chk("sil_wave_240", wave, 0);
      chk("sil_settled_240", settled, 0);
      chk("sil_edge_240", edge_cnt, 2);
      step(100);                                  // 340
      chk("sil_wave_340", wave, 0);
      cfg_we   = 1'b1;
      cfg_half = 8'd10;
      step(1);                                    // 341
      cfg_we   = 1'b0;
      chk("resume_341", settled, 0);
      step(1);                                    // 342
      chk("resume_run_342", settled, 1);
      chk("resume_wave_342", wave, 0);
      step(9);                                    // 351
      chk("resume_low_351", wave, 0);
      step(1);                                    // 352
      chk("resume_rise_352", wave, 1);
      chk("resume_edge_352", edge_cnt, 3);
      step(9);                                    // 361
      chk("resume_high_361", wave, 1);
      step(1);                                    // 362
      chk("resume_fall_362", wave, 0);

      // Select change coincident with a write to the new channel (G=30)
      select   = 2'b11;
      cfg_we   = 1'b1;
      cfg_sel  = 2'b11;
      cfg_half = 8'd30;
      step(1);                                    // 0
      cfg_we   = 1'b0;
      chk("coin_edge", edge_cnt, 0);
      chk("coin_settled", settled, 0);
      step(99);                                   // 99
      chk("coin_settle_99", settled, 0);
      step(1);                                    // 100
      chk("coin_run_100", settled, 1);
      step(29);                                   // 129
      chk("coin_low_129", wave, 0);
      step(1);                                    // 130
      chk("coin_rise_130", wave, 1);
      step(29);                                   // 159
      chk("coin_high_159", wave, 1);

      // Reset mid-period with a competing write; table reloads defaults
      rst      = 1'b1;
      select   = 2'b00;
      cfg_we   = 1'b1;
      cfg_sel  = 2'b00;
      cfg_half = 8'd99;
      step(1);                                    // 0
      rst      = 1'b0;
      cfg_we   = 1'b0;
      chk("rst2_wave", wave, 0);
      chk("rst2_settled", settled, 0);
      chk("rst2_edge", edge_cnt, 0);
      step(149);                                  // 149
      chk("rst2_r_low_149", wave, 0);
      step(1);                                    // 150
      chk("rst2_r_rise_150", wave, 1);
      select = 2'b11;
      step(1);                                    // G 0
      step(199);                                  // 199
      chk("rst2_g_low_199", wave, 0);
      step(1);                                    // 200
      chk("rst2_g_rise_200", wave, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
